// File: rtl/game_tick_if.sv
// Handshake bundle between the game tick scheduler and the snake control logic.
// The master is the game controller; the slave is the scheduler.
interface game_tick_if #(
    parameter int unsigned LVL_W = 4
);
    logic             restart;
    logic             run;
    logic             boost;
    logic             tick;
    logic             sec_tick;
    logic [LVL_W-1:0] level;
    logic             max_level;

    modport master (
        output restart,
        output run,
        output boost,
        input  tick,
        input  sec_tick,
        input  level,
        input  max_level
    );

    modport slave (
        input  restart,
        input  run,
        input  boost,
        output tick,
        output sec_tick,
        output level,
        output max_level
    );
endinterface

// File: rtl/game_tick_scheduler.sv
// Parametrised gameplay/seconds tick generator with level ladder, pause and restart.
// Optional feature: define SPEED_BOOST_EN to let boost halve the period at reload.
module game_tick_scheduler #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned BASE_PERIOD    = 10_000_000,
    parameter int unsigned PERIOD_STEP    = 1_000_000,
    parameter int unsigned LEVELS         = 6,
    parameter int unsigned LVL_W          = 4,
    parameter int unsigned SECS_PER_LEVEL = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    game_tick_if.slave  bus
);

    localparam logic [CNT_W-1:0] BASE_P    = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] STEP_P    = CNT_W'(PERIOD_STEP);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] SEC_LAST  = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] SPL_LAST  = CNT_W'(SECS_PER_LEVEL - 1);
    localparam logic [LVL_W-1:0] LVL_LAST  = LVL_W'(LEVELS - 1);

    // The shortest period must still leave a counter value to reload from.
    if (longint'(BASE_PERIOD) - longint'(LEVELS - 1) * longint'(PERIOD_STEP) < 64'sd2) begin : g_bad_period
        $error("game_tick_scheduler: BASE_PERIOD - (LEVELS-1)*PERIOD_STEP must be >= 2");
    end

    if ((64'd1 << LVL_W) < longint'(LEVELS)) begin : g_bad_lvl_w
        $error("game_tick_scheduler: LVL_W too narrow for LEVELS");
    end

    logic [CNT_W-1:0] tick_cnt_q,    tick_cnt_d;
    logic [CNT_W-1:0] sec_cnt_q,     sec_cnt_d;
    logic [CNT_W-1:0] secs_in_lvl_q, secs_in_lvl_d;
    logic [LVL_W-1:0] level_q,       level_d;
    logic             max_q,         max_d;
    logic             tick_q,        tick_d;
    logic             sec_q,         sec_d;

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] reload_val;

    // Period for the level held before this edge; constraint keeps it positive.
    always_comb begin
        period = BASE_P - (CNT_W'(level_q) * STEP_P);
    end

`ifdef SPEED_BOOST_EN
    always_comb begin
        if (bus.boost) begin
            reload_val = (period >> 1) - ONE;
        end else begin
            reload_val = period - ONE;
        end
    end
`else
    logic unused_boost;
    assign unused_boost = bus.boost;

    always_comb begin
        reload_val = period - ONE;
    end
`endif

    // Next-state logic: restart beats run; a paused edge holds state and drops pulses.
    always_comb begin
        tick_cnt_d    = tick_cnt_q;
        sec_cnt_d     = sec_cnt_q;
        secs_in_lvl_d = secs_in_lvl_q;
        level_d       = level_q;
        max_d         = max_q;
        tick_d        = 1'b0;
        sec_d         = 1'b0;

        if (bus.restart) begin
            tick_cnt_d    = BASE_P - ONE;
            sec_cnt_d     = '0;
            secs_in_lvl_d = '0;
            level_d       = '0;
            max_d         = 1'b0;
        end else if (bus.run) begin
            if (tick_cnt_q == '0) begin
                tick_d     = 1'b1;
                tick_cnt_d = reload_val;
            end else begin
                tick_cnt_d = tick_cnt_q - ONE;
            end

            if (sec_cnt_q == SEC_LAST) begin
                sec_d     = 1'b1;
                sec_cnt_d = '0;
                // Top level saturates; its seconds count is frozen too.
                if (level_q == LVL_LAST) begin
                    level_d = level_q;
                end else if (secs_in_lvl_q == SPL_LAST) begin
                    level_d       = level_q + LVL_W'(1);
                    secs_in_lvl_d = '0;
                end else begin
                    secs_in_lvl_d = secs_in_lvl_q + ONE;
                end
                max_d = (level_d == LVL_LAST);
            end else begin
                sec_cnt_d = sec_cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt_q    <= BASE_P - ONE;
            sec_cnt_q     <= '0;
            secs_in_lvl_q <= '0;
            level_q       <= '0;
            max_q         <= 1'b0;
            tick_q        <= 1'b0;
            sec_q         <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            sec_cnt_q     <= sec_cnt_d;
            secs_in_lvl_q <= secs_in_lvl_d;
            level_q       <= level_d;
            max_q         <= max_d;
            tick_q        <= tick_d;
            sec_q         <= sec_d;
        end
    end

    assign bus.tick      = tick_q;
    assign bus.sec_tick  = sec_q;
    assign bus.level     = level_q;
    assign bus.max_level = max_q;

endmodule
